// File: rtl/byte_to_word_bridge.sv
// Byte-wide master to 32-bit word memory bridge (big-endian lanes). Coalesces byte
// writes to one word into a single masked word write; a one-word cache serves byte reads.
module byte_to_word_bridge #(
  parameter int unsigned read_cycles = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] byte_addr,
  input  logic        byte_wr,
  input  logic [7:0]  byte_wr_data,
  input  logic        byte_rd,
  output logic        byte_ready,
  output logic [7:0]  byte_rd_data,
  output logic        byte_rd_valid,
  input  logic        flush,
  output logic [31:0] word_addr,
  output logic [31:0] word_wr_data,
  output logic [3:0]  word_be,
  output logic        word_wr,
  output logic        word_rd,
  input  logic [31:0] word_rd_data
);

  typedef enum logic [1:0] {IDLE, FLUSH, RD_WAIT, RESP} state_t;

  localparam logic [3:0] LP_LAST = 4'(read_cycles - 1);

  state_t      r_state;
  state_t      w_next;
  logic [29:0] r_buf_addr;
  logic [31:0] r_buf_data;
  logic [3:0]  r_pend_be;
  logic [29:0] r_cache_tag;
  logic [31:0] r_cache_data;
  logic        r_cache_valid;
  logic [29:0] r_rd_tag;
  logic [1:0]  r_rd_off;
  logic [3:0]  r_cnt;

  logic [29:0] w_req_tag;
  logic [3:0]  w_lane_be;
  logic [31:0] w_be_mask;
  logic        w_pend;
  logic        w_same_word;
  logic        w_hit;
  logic        w_flush_hits_cache;
  logic        w_last;
  logic        w_wr_acc;
  logic        w_rd_acc;

  assign w_req_tag          = byte_addr[31:2];
  assign w_lane_be          = 4'b1000 >> byte_addr[1:0];
  assign w_pend             = |r_pend_be;
  assign w_same_word        = (w_req_tag == r_buf_addr);
  assign w_hit              = r_cache_valid && (r_cache_tag == w_req_tag);
  assign w_flush_hits_cache = r_cache_valid && (r_cache_tag == r_buf_addr);
  assign w_last             = (r_cnt == LP_LAST);
  assign w_be_mask          = {{8{r_pend_be[3]}}, {8{r_pend_be[2]}},
                               {8{r_pend_be[1]}}, {8{r_pend_be[0]}}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    w_next        = r_state;
    w_wr_acc      = 1'b0;
    w_rd_acc      = 1'b0;
    byte_ready    = 1'b0;
    byte_rd_valid = 1'b0;
    byte_rd_data  = 8'h00;
    word_wr       = 1'b0;
    word_rd       = 1'b0;
    word_addr     = 32'h0;
    word_be       = 4'h0;
    word_wr_data  = 32'h0;
    case (r_state)
      IDLE: begin
        if (flush && w_pend) begin
          w_next = FLUSH;
        end else if (byte_wr) begin
          if (!w_pend || w_same_word) begin
            byte_ready = 1'b1;
            w_wr_acc   = 1'b1;
            if ((r_pend_be | w_lane_be) == 4'hF) w_next = FLUSH;
          end else begin
            w_next = FLUSH;
          end
        end else if (byte_rd) begin
          if (w_pend) begin
            w_next = FLUSH;
          end else begin
            byte_ready = 1'b1;
            w_rd_acc   = 1'b1;
            w_next     = w_hit ? RESP : RD_WAIT;
          end
        end else begin
          byte_ready = 1'b1;
        end
      end
      FLUSH: begin
        word_wr      = 1'b1;
        word_addr    = {r_buf_addr, 2'b00};
        word_be      = r_pend_be;
        word_wr_data = r_buf_data & w_be_mask;
        w_next       = IDLE;
      end
      RD_WAIT: begin
        word_addr = {r_rd_tag, 2'b00};
        word_rd   = (r_cnt == 4'd0);
        if (w_last) w_next = RESP;
      end
      RESP: begin
        byte_rd_valid = 1'b1;
        case (r_rd_off)
          2'd0:    byte_rd_data = r_cache_data[31:24];
          2'd1:    byte_rd_data = r_cache_data[23:16];
          2'd2:    byte_rd_data = r_cache_data[15:8];
          default: byte_rd_data = r_cache_data[7:0];
        endcase
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf_addr    <= '0;
      r_buf_data    <= '0;
      r_pend_be     <= '0;
      r_cache_tag   <= '0;
      r_cache_data  <= '0;
      r_cache_valid <= 1'b0;
      r_rd_tag      <= '0;
      r_rd_off      <= '0;
      r_cnt         <= '0;
    end else begin
      if (w_wr_acc) begin
        if (!w_pend) r_buf_addr <= w_req_tag;
        r_pend_be <= r_pend_be | w_lane_be;
        for (int i = 0; i < 4; i++)
          if (w_lane_be[i]) r_buf_data[8*i +: 8] <= byte_wr_data;
      end
      // The cache stays coherent by absorbing the lanes of a flush to its own word.
      if (r_state == FLUSH) begin
        r_pend_be <= '0;
        if (w_flush_hits_cache)
          for (int i = 0; i < 4; i++)
            if (r_pend_be[i]) r_cache_data[8*i +: 8] <= r_buf_data[8*i +: 8];
      end
      if (w_rd_acc) begin
        r_rd_tag <= w_req_tag;
        r_rd_off <= byte_addr[1:0];
        r_cnt    <= '0;
      end
      if (r_state == RD_WAIT) begin
        if (w_last) begin
          r_cache_data  <= word_rd_data;
          r_cache_tag   <= r_rd_tag;
          r_cache_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_byte_to_word_bridge.sv
// Self-checking bench for byte_to_word_bridge: directed scenarios, then random byte
// traffic checked against a byte-addressed memory model and a one-word cache model.
module tb_byte_to_word_bridge;

  localparam int unsigned RC = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] byte_addr = '0;
  logic        byte_wr = 1'b0;
  logic [7:0]  byte_wr_data = '0;
  logic        byte_rd = 1'b0;
  logic        byte_ready;
  logic [7:0]  byte_rd_data;
  logic        byte_rd_valid;
  logic        flush = 1'b0;
  logic [31:0] word_addr;
  logic [31:0] word_wr_data;
  logic [3:0]  word_be;
  logic        word_wr;
  logic        word_rd;
  logic [31:0] word_rd_data = 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  byte_to_word_bridge #(.read_cycles(RC)) dut (
    .clk(clk), .reset_n(reset_n),
    .byte_addr(byte_addr), .byte_wr(byte_wr), .byte_wr_data(byte_wr_data),
    .byte_rd(byte_rd), .byte_ready(byte_ready), .byte_rd_data(byte_rd_data),
    .byte_rd_valid(byte_rd_valid), .flush(flush),
    .word_addr(word_addr), .word_wr_data(word_wr_data), .word_be(word_be),
    .word_wr(word_wr), .word_rd(word_rd), .word_rd_data(word_rd_data)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word memory behind the bridge, plus the reference byte image of what the master wrote.
  logic [31:0] mem     [bit [29:0]];
  logic [7:0]  model_b [bit [31:0]];

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return ({w, 2'b00} * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] mem_word(input logic [29:0] w);
    if (mem.exists(w)) return mem[w];
    return init_word(w);
  endfunction

  function automatic logic [7:0] model_byte(input logic [31:0] a);
    logic [31:0] w;
    if (model_b.exists(a)) return model_b[a];
    w = init_word(a[31:2]);
    return w[8*(3 - int'(a[1:0])) +: 8];
  endfunction

  // Bus monitor and memory responder, sampled on the falling edge.
  int          ncyc = 0, n_wr = 0, n_rd = 0, n_valid = 0, wr_cyc = 0, rd_cd = 0;
  logic [31:0] last_wa, last_wd;
  logic [3:0]  last_be;
  logic [29:0] rd_w;

  always @(negedge clk) begin
    logic [31:0] tmp;
    ncyc++;
    word_rd_data = 32'hDEAD_BEEF;
    if (rd_cd > 0) begin
      rd_cd--;
      if (rd_cd == 0) word_rd_data = mem_word(rd_w);
    end
    if (byte_rd_valid) n_valid++;
    if (word_wr) begin
      n_wr++;
      wr_cyc  = ncyc;
      last_wa = word_addr;
      last_be = word_be;
      last_wd = word_wr_data;
      check("wr_disabled_lanes_zero", word_wr_data & ~{{8{word_be[3]}}, {8{word_be[2]}},
            {8{word_be[1]}}, {8{word_be[0]}}}, 32'h0);
      check("wr_addr_aligned", 32'(word_addr[1:0]), 32'h0);
      check("wr_rd_exclusive", 32'(word_rd), 32'h0);
      tmp = mem_word(word_addr[31:2]);
      for (int i = 0; i < 4; i++)
        if (word_be[i]) tmp[8*i +: 8] = word_wr_data[8*i +: 8];
      mem[word_addr[31:2]] = tmp;
    end
    if (word_rd) begin
      n_rd++;
      rd_w  = word_addr[31:2];
      rd_cd = RC - 1;
      if (RC == 1) word_rd_data = mem_word(rd_w);
    end
  end

  int first_cyc, last_acc;

  task automatic wait_ready(output int waited);
    waited = 0;
    #1;
    first_cyc = ncyc;
    while (!byte_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!byte_ready) begin
      n_checks++;
      n_fail++;
      $error("FAIL ready_timeout: observed byte_ready=0 expected 1 within 50 cycles");
    end
    last_acc = ncyc;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    int w;
    byte_addr    = a;
    byte_wr_data = d;
    byte_wr      = 1'b1;
    wait_ready(w);
    @(negedge clk);
    byte_wr = 1'b0;
    byte_rd = 1'b0;
    model_b[a] = d;
  endtask

  task automatic rd(input logic [31:0] a, output logic [7:0] d, output int lat);
    int w;
    byte_addr = a;
    byte_rd   = 1'b1;
    wait_ready(w);
    @(negedge clk);
    byte_rd = 1'b0;
    lat     = 1;
    #1;
    while (!byte_rd_valid && lat < 40) begin
      @(negedge clk);
      #1;
      lat++;
    end
    if (!byte_rd_valid) begin
      n_checks++;
      n_fail++;
      $error("FAIL rd_timeout: observed no byte_rd_valid expected one within 40 cycles");
    end
    d = byte_rd_data;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test expected finish before 500us");
    $fatal(1);
  end

  initial begin
    logic [7:0]  t1_data [4];
    logic [7:0]  t4_data [4];
    logic [7:0]  got;
    int          lat, n0, r0, v0;
    logic        mc_valid;
    logic [29:0] mc_tag;

    t1_data = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    t4_data = '{8'h12, 8'h34, 8'h56, 8'h78};

    // Reset values.
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(byte_ready), 32'h1);
    check("rst_rd_out", {23'h0, byte_rd_valid, byte_rd_data}, 32'h0);
    check("rst_strobes", {26'h0, word_wr, word_rd, word_be}, 32'h0);
    check("rst_word_addr", word_addr, 32'h0);
    check("rst_word_data", word_wr_data, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);

    // Four lanes of one word coalesce into one full word write.
    n0 = n_wr; r0 = n_rd;
    for (int i = 0; i < 4; i++) wr(32'h100 + 32'(i), t1_data[i]);
    idle(3);
    check("t1_wr_count", 32'(n_wr - n0), 32'd1);
    check("t1_rd_count", 32'(n_rd - r0), 32'd0);
    check("t1_wr_latency", 32'(wr_cyc - last_acc), 32'd1);
    check("t1_addr", last_wa, 32'h100);
    check("t1_be", 32'(last_be), 32'hF);
    check("t1_data", last_wd, 32'hAABB_CCDD);

    // A write to a different word forces the pending one out first.
    n0 = n_wr;
    wr(32'h201, 8'h11);
    wr(32'h300, 8'h77);
    check("t2_flush_next_cycle", 32'(wr_cyc - first_cyc), 32'd1);
    check("t2_accept_after_flush", 32'(last_acc - wr_cyc), 32'd1);
    check("t2_addr", last_wa, 32'h200);
    check("t2_be", 32'(last_be), 32'h4);
    check("t2_data", last_wd, 32'h0011_0000);
    flush_pulse();
    idle(2);
    check("t2_wr_count", 32'(n_wr - n0), 32'd2);
    check("t2_second_addr", last_wa, 32'h300);
    check("t2_second_be", 32'(last_be), 32'h8);
    check("t2_second_data", last_wd, 32'h7700_0000);

    // Explicit flush, then a flush with nothing pending.
    wr(32'h402, 8'h55);
    flush_pulse();
    idle(2);
    check("t3_addr", last_wa, 32'h400);
    check("t3_be", 32'(last_be), 32'h2);
    check("t3_data", last_wd, 32'h0000_5500);
    n0 = n_wr;
    flush_pulse();
    idle(3);
    check("t3_empty_flush", 32'(n_wr - n0), 32'd0);

    // Sequential byte reads cost a single word read.
    mem[30'h140] = 32'h1234_5678;
    r0 = n_rd;
    for (int i = 0; i < 4; i++) begin
      rd(32'h500 + 32'(i), got, lat);
      check($sformatf("t4_data_%0d", i), 32'(got), 32'(t4_data[i]));
      check($sformatf("t4_lat_%0d", i), 32'(lat), (i == 0) ? RC + 1 : 32'd1);
    end
    check("t4_rd_count", 32'(n_rd - r0), 32'd1);

    // Write into the cached word is flushed and merged into the cache.
    r0 = n_rd;
    rd(32'h600, got, lat);
    check("t5_first_data", 32'(got), 32'(model_byte(32'h600)));
    n0 = n_wr;
    wr(32'h601, 8'h9A);
    rd(32'h601, got, lat);
    check("t5_hit_data", 32'(got), 32'h9A);
    check("t5_hit_lat", 32'(lat), 32'd1);
    check("t5_rd_count", 32'(n_rd - r0), 32'd1);
    check("t5_wr_count", 32'(n_wr - n0), 32'd1);
    check("t5_flush_addr", last_wa, 32'h600);
    check("t5_flush_be", 32'(last_be), 32'h4);
    check("t5_flush_data", last_wd, 32'h009A_0000);

    // Simultaneous write and read: only the write is taken.
    v0 = n_valid; r0 = n_rd;
    byte_rd = 1'b1;
    wr(32'h900, 8'h3C);
    idle(3);
    check("prio_no_read_resp", 32'(n_valid - v0), 32'd0);
    check("prio_no_word_rd", 32'(n_rd - r0), 32'd0);
    flush_pulse();
    idle(2);
    check("prio_wr_addr", last_wa, 32'h900);
    check("prio_wr_data", last_wd, 32'h3C00_0000);

    // Reset with a pending write discards it.
    n0 = n_wr;
    wr(32'h800, 8'h42);
    reset_n = 1'b0;
    #1;
    check("rst_pend_strobes", {26'h0, word_wr, word_rd, word_be}, 32'h0);
    check("rst_pend_ready", 32'(byte_ready), 32'h1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    flush_pulse();
    idle(3);
    check("rst_pend_discarded", 32'(n_wr - n0), 32'd0);

    // Reset during RD_WAIT kills the read immediately.
    byte_addr = 32'h700;
    byte_rd   = 1'b1;
    wait_ready(lat);
    @(negedge clk);
    byte_rd = 1'b0;
    #1;
    check("rdwait_word_rd", 32'(word_rd), 32'h1);
    reset_n = 1'b0;
    #1;
    check("rdwait_rst_strobes", {26'h0, word_wr, word_rd, word_be}, 32'h0);
    check("rdwait_rst_addr", word_addr, 32'h0);
    check("rdwait_rst_rd_out", {23'h0, byte_rd_valid, byte_rd_data}, 32'h0);
    n0 = n_wr; r0 = n_rd; v0 = n_valid;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(5);
    check("rdwait_no_wr", 32'(n_wr - n0), 32'd0);
    check("rdwait_no_rd", 32'(n_rd - r0), 32'd0);
    check("rdwait_no_valid", 32'(n_valid - v0), 32'd0);
    check("rdwait_ready", 32'(byte_ready), 32'h1);

    // The cache was invalidated by reset: a previously cached word misses again.
    r0 = n_rd;
    rd(32'h601, got, lat);
    check("post_rst_data", 32'(got), 32'h9A);
    check("post_rst_lat", 32'(lat), RC + 1);
    check("post_rst_rd_count", 32'(n_rd - r0), 32'd1);
    mc_valid = 1'b1;
    mc_tag   = 30'h180;

    // Random traffic over 16 words against the byte model and cache model.
    for (int k = 0; k < 300; k++) begin
      int unsigned r;
      logic [31:0] a;
      logic [7:0]  exp_b;
      logic        hit;
      r = $urandom_range(0, 99);
      a = 32'h1000 + 32'($urandom_range(0, 63));
      if (r < 45) begin
        wr(a, 8'($urandom));
      end else if (r < 90) begin
        exp_b = model_byte(a);
        hit   = mc_valid && (mc_tag == a[31:2]);
        r0    = n_rd;
        rd(a, got, lat);
        check($sformatf("rnd_data_%0d_%h", k, a), 32'(got), 32'(exp_b));
        check($sformatf("rnd_lat_%0d", k), 32'(lat), hit ? 32'd1 : RC + 1);
        check($sformatf("rnd_rd_count_%0d", k), 32'(n_rd - r0), hit ? 32'd0 : 32'd1);
        mc_valid = 1'b1;
        mc_tag   = a[31:2];
      end else begin
        flush_pulse();
      end
    end
    flush_pulse();
    idle(3);
    for (int w = 0; w < 16; w++) begin
      logic [31:0] base;
      logic [31:0] exp_w;
      base  = 32'h1000 + 32'(4 * w);
      exp_w = {model_byte(base), model_byte(base + 1), model_byte(base + 2), model_byte(base + 3)};
      check($sformatf("final_mem_%h", base), mem_word(base[31:2]), exp_w);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
